uart_result_encoder: RTL and testbench
======================================

// Module: uart_result_encoder
// PURPOSE
//  Converts one ALU result word into an ASCII byte stream for the UART transmitter.
//  Sits between the ALU (alu_done/calc_res) and uart_tx in the UART calculator.
//  Emits uppercase hex digits with optional sign and leading-zero suppression, then a line terminator.
//  Also emits an error string, one byte per valid/ready handshake.
// PARAMETERS
//  DATA_W      32  result width in bits; multiple of 4, range 8..64; NDIG = DATA_W/4
//  SIGNED_EN   1   1: honour calc_signed; 0: always treat the result as unsigned
//  LZ_SUPPRESS 1   1: skip leading zero nibbles (value 0 prints "0"); 0: print all NDIG digits
//  TERM_MODE   2   0: no terminator; 1: LF (0x0A); 2: CR LF (0x0D 0x0A)
// PORTS
//  clk          in   1       system clock
//  rst          in   1       reset; asynchronous, active-high
//  alu_done     in   1       1-cycle pulse: calc_res/calc_signed/alu_err valid
//  alu_err      in   1       ALU error (e.g. divide by zero), sampled with alu_done
//  calc_signed  in   1       result is two's complement (parser dtype S)
//  calc_res     in   DATA_W  ALU result
//  tx_ready     in   1       uart_tx can accept a byte this cycle
//  tx_data      out  8       ASCII byte to transmit
//  uout_valid   out  1       tx_data valid; held until accepted
//  enc_busy     out  1       frame in progress (state != IDLE)
//  enc_done     out  1       1-cycle pulse after the last byte of a frame is accepted
//  enc_ovr      out  1       1-cycle pulse: alu_done arrived while busy, request dropped
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-high.
//  Reset: all outputs 0, state IDLE, internal registers 0. Reset mid-frame abandons the frame; no resume.
//  Handshake: a byte transfers on a rising edge with uout_valid && tx_ready.
//   - tx_data is stable while uout_valid && !tx_ready.
//   - Next byte, or valid low after the last byte, appears on that same edge.
//   - Back-to-back transfers at 1 byte/cycle are supported.
//  Capture, in IDLE on alu_done:
//   - err_q <= alu_err.
//   - neg_q <= SIGNED_EN && calc_signed && calc_res[DATA_W-1].
//   - mag_q <= neg_q ? -calc_res : calc_res, computed modulo 2^DATA_W.
//   - The most negative value prints as its own magnitude, e.g. 0x80000000 -> "-80000000".
//   - idx_q <= index of the MS nonzero nibble of mag, or 0 if mag == 0; NDIG-1 when LZ_SUPPRESS=0.
//   - First byte is valid on the next edge: latency 1 cycle from alu_done to uout_valid.
//  FSM: IDLE, ERR, SIGN, DIGIT, CR, LF.
//   - IDLE -> ERR if alu_err; else -> SIGN if neg; else -> DIGIT.
//   - ERR sends 'E','R','R' (0x45,0x52,0x52), using a 2-bit count; -> terminator.
//   - SIGN sends '-' (0x2D) -> DIGIT.
//   - DIGIT sends nibble mag_q[4*idx+3:4*idx], with idx decremented per accepted byte.
//   - DIGIT ends after idx 0 -> terminator.
//   - Terminator: TERM_MODE 2 sends CR then LF; TERM_MODE 1 sends LF only; TERM_MODE 0 -> IDLE directly.
//   - Last byte accepted -> IDLE, uout_valid 0, enc_done=1 for exactly one cycle.
//  Nibble encoding: 0..9 -> 0x30+n; 10..15 -> 0x41+(n-10), i.e. 'A'..'F'.
//  Overrun: alu_done while not IDLE is ignored; enc_ovr pulses 1 cycle; the current frame is unaffected.
//  alu_done in the same cycle enc_done is high is accepted, because the FSM is already IDLE.
//  Inputs are sampled only on capture; calc_res may change afterwards.
// TESTING
//  1 Unsigned 0x00001A2F, tx_ready=1
//    -> '1','A','2','F',0x0D,0x0A on 6 consecutive cycles; enc_done 1 cycle later.
//  2 Signed 0xFFFFFFFE -> '-','2',CR,LF.
//    Signed 0x80000000 -> '-','8', then seven '0', CR, LF.
//    Same word with calc_signed=0 -> '8' plus seven '0'.
//  3 calc_res=0 -> '0',CR,LF. With LZ_SUPPRESS=0 -> eight '0' then CR,LF.
//  4 alu_err=1 with any calc_res -> 'E','R','R',CR,LF; no sign or digits.
//  5 tx_ready toggling 1-of-3 cycles: tx_data stable until accepted; no byte lost or duplicated.
//    alu_done mid-frame -> enc_ovr pulse; stream unchanged.
//  6 rst asserted after 2 bytes of a frame -> uout_valid/enc_busy 0 immediately.
//    Next alu_done with 0x7 -> '7',CR,LF cleanly.

Source files
------------

// File: rtl/uart_result_encoder.sv
`default_nettype none
// ============================================================================
// Module   : uart_result_encoder
// Purpose  : Turns one ALU result into an ASCII hex (or "ERR") byte stream,
//            followed by an optional line terminator, for the UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module uart_result_encoder #(
  parameter int DATA_W      = 32,
  parameter int SIGNED_EN   = 1,
  parameter int LZ_SUPPRESS = 1,
  parameter int TERM_MODE   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_done,
  input  logic              alu_err,
  input  logic              calc_signed,
  input  logic [DATA_W-1:0] calc_res,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic              uout_valid,
  output logic              enc_busy,
  output logic              enc_done,
  output logic              enc_ovr
);

  localparam int NDIG = DATA_W / 4;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] C_IDX_MAX = IW'(NDIG - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ERR   = 3'd1,
    S_SIGN  = 3'd2,
    S_DIGIT = 3'd3,
    S_CR    = 3'd4,
    S_LF    = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  state_t              w_term_state;
  logic [DATA_W-1:0]   r_mag;
  logic [IW-1:0]       r_idx;
  logic [1:0]          r_ecnt;
  logic                r_done;
  logic                r_ovr;

  logic                w_cap_neg;
  logic [DATA_W-1:0]   w_cap_mag;
  logic [IW-1:0]       w_lead_idx;
  logic [IW-1:0]       w_cap_idx;
  logic                w_accept;
  logic                w_last;
  logic [3:0]          w_nib;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h37 + {4'd0, n});
  endfunction

  // Capture-side datapath: sign, magnitude (mod 2^DATA_W) and first digit index
  assign w_cap_neg = (SIGNED_EN != 0) && calc_signed && calc_res[DATA_W-1];
  assign w_cap_mag = w_cap_neg ? -calc_res : calc_res;

  always_comb begin
    w_lead_idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (w_cap_mag[4*i +: 4] != 4'd0) begin
        w_lead_idx = IW'(i);
      end
    end
  end

  assign w_cap_idx = (LZ_SUPPRESS != 0) ? w_lead_idx : C_IDX_MAX;

  assign uout_valid = (r_state != S_IDLE);
  assign enc_busy   = (r_state != S_IDLE);
  assign w_accept   = (r_state != S_IDLE) && tx_ready;
  assign w_last     = (r_state != S_IDLE) && (w_state_nxt == S_IDLE);
  assign w_nib      = 4'(r_mag >> {r_idx, 2'b00});
  assign enc_done   = r_done;
  assign enc_ovr    = r_ovr;

  always_comb begin
    w_term_state = S_IDLE;
    if (TERM_MODE == 2) begin
      w_term_state = S_CR;
    end else if (TERM_MODE == 1) begin
      w_term_state = S_LF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    tx_data     = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (alu_done) begin
          if (alu_err) begin
            w_state_nxt = S_ERR;
          end else if (w_cap_neg) begin
            w_state_nxt = S_SIGN;
          end else begin
            w_state_nxt = S_DIGIT;
          end
        end
      end
      S_ERR: begin
        tx_data = (r_ecnt == 2'd0) ? 8'h45 : 8'h52;
        if (w_accept && (r_ecnt == 2'd2)) begin
          w_state_nxt = w_term_state;
        end
      end
      S_SIGN: begin
        tx_data = 8'h2D;
        if (w_accept) begin
          w_state_nxt = S_DIGIT;
        end
      end
      S_DIGIT: begin
        tx_data = hex_ascii(w_nib);
        if (w_accept && (r_idx == '0)) begin
          w_state_nxt = w_term_state;
        end
      end
      S_CR: begin
        tx_data = 8'h0D;
        if (w_accept) begin
          w_state_nxt = S_LF;
        end
      end
      S_LF: begin
        tx_data = 8'h0A;
        if (w_accept) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Frame registers only move on capture or on an accepted byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mag  <= '0;
      r_idx  <= '0;
      r_ecnt <= 2'd0;
    end else if ((r_state == S_IDLE) && alu_done) begin
      r_mag  <= w_cap_mag;
      r_idx  <= w_cap_idx;
      r_ecnt <= 2'd0;
    end else if (w_accept) begin
      if (r_state == S_ERR) begin
        r_ecnt <= r_ecnt + 2'd1;
      end
      if ((r_state == S_DIGIT) && (r_idx != '0)) begin
        r_idx <= r_idx - IW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      r_done <= w_last;
      r_ovr  <= alu_done && (r_state != S_IDLE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_result_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_result_encoder
// Purpose  : Self-checking bench for uart_result_encoder against a digit model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_result_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_done, alu_done2, alu_err, calc_signed, tx_ready;
  logic [31:0] calc_res;
  logic [7:0]  tx_data, tx_data2;
  logic        uout_valid, enc_busy, enc_done, enc_ovr;
  logic        uout_valid2, enc_busy2, enc_done2, enc_ovr2;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  bit fr_first_ok, fr_stable_ok, fr_done_ok, fr_done_early, fr_timeout, fr_ovr_seen;
  int fr_cycles;

  always #5 clk = ~clk;

  uart_result_encoder dut (
    .clk(clk), .rst(rst), .alu_done(alu_done), .alu_err(alu_err),
    .calc_signed(calc_signed), .calc_res(calc_res), .tx_ready(tx_ready),
    .tx_data(tx_data), .uout_valid(uout_valid), .enc_busy(enc_busy),
    .enc_done(enc_done), .enc_ovr(enc_ovr)
  );

  uart_result_encoder #(.LZ_SUPPRESS(0), .TERM_MODE(1)) dut_nz (
    .clk(clk), .rst(rst), .alu_done(alu_done2), .alu_err(alu_err),
    .calc_signed(calc_signed), .calc_res(calc_res), .tx_ready(tx_ready),
    .tx_data(tx_data2), .uout_valid(uout_valid2), .enc_busy(enc_busy2),
    .enc_done(enc_done2), .enc_ovr(enc_ovr2)
  );

  function automatic logic [7:0] hexc(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(55 + n);
  endfunction

  // Reference: decimal-free digit peeling by repeated division by 16
  function automatic void build_exp(input logic [31:0] res, input bit sgn, input bit err,
                                    input bit lz, input int term);
    logic [7:0] dq[$];
    longint unsigned v;
    int n;
    exp_q.delete();
    if (err) begin
      exp_q = {8'h45, 8'h52, 8'h52};
    end else begin
      v = 64'(res);
      if (sgn && res[31]) begin
        exp_q.push_back(8'h2D);
        v = 64'h1_0000_0000 - v;
      end
      n = lz ? 0 : 8;
      do begin
        dq.push_front(hexc(int'(v % 16)));
        v = v / 16;
        n--;
      end while (v != 0 || n > 0);
      foreach (dq[i]) exp_q.push_back(dq[i]);
    end
    if (term == 2) exp_q.push_back(8'h0D);
    if (term >= 1) exp_q.push_back(8'h0A);
  endfunction

  function automatic bit same_q();
    if (got_q.size() != exp_q.size()) return 1'b0;
    foreach (got_q[i]) if (got_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic string qstr(input logic [7:0] q[$]);
    string s = "";
    foreach (q[i]) if (i < 24) s = {s, $sformatf("%02h ", q[i])};
    return s;
  endfunction

  // Drives one request (called at a negedge) and collects accepted bytes
  task automatic run_frame(input bit sel, input logic [31:0] res, input bit sgn, input bit err,
                           input int rmode, input int ovr_at);
    logic v, dn, ov;
    logic [7:0] d, held;
    bit held_valid = 0, ovr_pending = 0;
    int cyc = 0;
    got_q.delete();
    fr_stable_ok = 1; fr_done_ok = 0; fr_done_early = 0; fr_timeout = 0;
    fr_ovr_seen = 0; fr_cycles = 0;
    calc_res = res; calc_signed = sgn; alu_err = err;
    if (sel) alu_done2 = 1'b1; else alu_done = 1'b1;
    tx_ready = 1'b0;
    @(negedge clk);
    alu_done = 1'b0; alu_done2 = 1'b0;
    calc_res = $urandom; calc_signed = 1'($urandom); alu_err = 1'($urandom);
    fr_first_ok = sel ? uout_valid2 : uout_valid;
    while (1) begin
      v  = sel ? uout_valid2 : uout_valid;
      d  = sel ? tx_data2    : tx_data;
      dn = sel ? enc_done2   : enc_done;
      ov = sel ? enc_ovr2    : enc_ovr;
      alu_done = 1'b0; alu_done2 = 1'b0;
      if (ovr_pending) begin fr_ovr_seen = ov; ovr_pending = 0; end
      if (!v) begin fr_done_ok = dn; break; end
      if (dn) fr_done_early = 1;
      if (held_valid && d !== held) fr_stable_ok = 0;
      if (cyc >= 200) begin fr_timeout = 1; break; end
      case (rmode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = (cyc % 3 == 2);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      if (cyc == ovr_at) begin
        if (sel) alu_done2 = 1'b1; else alu_done = 1'b1;
        calc_res = $urandom;
        ovr_pending = 1;
      end
      if (tx_ready) begin got_q.push_back(d); held_valid = 0; end
      else begin held = d; held_valid = 1; end
      fr_cycles++;
      cyc++;
      @(negedge clk);
    end
    tx_ready = 1'b0; alu_done = 1'b0; alu_done2 = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if ({uout_valid, enc_busy, enc_done, enc_ovr, tx_data} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_outputs: got v=%b b=%b d=%b o=%b data=%02h, want all 0",
               uout_valid, enc_busy, enc_done, enc_ovr, tx_data);
    end
    tests_run++;
    if ({uout_valid2, enc_busy2, enc_done2, enc_ovr2, tx_data2} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_outputs_nz: got v=%b data=%02h, want 0", uout_valid2, tx_data2);
    end
  endtask

  task automatic test_hex_unsigned();
    run_frame(0, 32'h0000_1A2F, 0, 0, 0, -1);
    exp_q = {8'h31, 8'h41, 8'h32, 8'h46, 8'h0D, 8'h0A};
    tests_run++;
    if (!fr_first_ok) begin
      tests_failed++; $display("FAIL hex_latency: uout_valid=0 one cycle after alu_done, want 1");
    end
    tests_run++;
    if (!same_q()) begin
      tests_failed++; $display("FAIL hex_stream: got %s want %s", qstr(got_q), qstr(exp_q));
    end
    tests_run++;
    if (fr_cycles != 6 || !fr_done_ok || fr_done_early) begin
      tests_failed++;
      $display("FAIL hex_timing: cycles=%0d done=%b early=%b, want 6/1/0",
               fr_cycles, fr_done_ok, fr_done_early);
    end
  endtask

  task automatic test_signed();
    logic [31:0] vals[3] = '{32'hFFFF_FFFE, 32'h8000_0000, 32'h8000_0000};
    bit          sgns[3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      run_frame(0, vals[i], sgns[i], 0, 0, -1);
      build_exp(vals[i], sgns[i], 0, 1, 2);
      tests_run++;
      if (!same_q() || !fr_done_ok) begin
        tests_failed++;
        $display("FAIL signed_%0d: got %s want %s done=%b", i, qstr(got_q), qstr(exp_q), fr_done_ok);
      end
    end
  endtask

  task automatic test_zero();
    logic [31:0] r;
    run_frame(0, 32'h0, 0, 0, 0, -1);
    exp_q = {8'h30, 8'h0D, 8'h0A};
    tests_run++;
    if (!same_q()) begin
      tests_failed++; $display("FAIL zero_lz: got %s want %s", qstr(got_q), qstr(exp_q));
    end
    run_frame(1, 32'h0, 1, 0, 0, -1);
    build_exp(32'h0, 1, 0, 0, 1);
    tests_run++;
    if (!same_q() || !fr_done_ok) begin
      tests_failed++; $display("FAIL zero_nolz: got %s want %s", qstr(got_q), qstr(exp_q));
    end
    for (int i = 0; i < 4; i++) begin
      r = $urandom >> $urandom_range(0, 31);
      run_frame(1, r, 1'($urandom), 0, 2, -1);
      build_exp(r, calc_signed_hist(), 0, 0, 1);
    end
  endtask

  // Sign used by the last frame is not kept by run_frame, so zero-LZ random
  // frames are checked in test_nolz_random instead; this stub keeps types simple.
  function automatic bit calc_signed_hist();
    return 1'b0;
  endfunction

  task automatic test_nolz_random();
    logic [31:0] r;
    bit s;
    for (int i = 0; i < 6; i++) begin
      r = $urandom >> $urandom_range(0, 31);
      s = 1'($urandom);
      run_frame(1, r, s, 0, 2, -1);
      build_exp(r, s, 0, 0, 1);
      tests_run++;
      if (!same_q() || !fr_stable_ok || fr_timeout) begin
        tests_failed++;
        $display("FAIL nolz_rand_%0d: res=%08h s=%b got %s want %s", i, r, s, qstr(got_q), qstr(exp_q));
      end
    end
  endtask

  task automatic test_error();
    logic [31:0] r;
    for (int i = 0; i < 3; i++) begin
      r = (i == 0) ? 32'hFFFF_FFFF : $urandom;
      run_frame(0, r, 1'(i), 1, 2, -1);
      exp_q = {8'h45, 8'h52, 8'h52, 8'h0D, 8'h0A};
      tests_run++;
      if (!same_q() || !fr_done_ok) begin
        tests_failed++; $display("FAIL error_%0d: got %s want %s", i, qstr(got_q), qstr(exp_q));
      end
    end
  endtask

  task automatic test_slow_ready_overrun();
    logic [31:0] r = 32'hDEAD_BEEF;
    run_frame(0, r, 0, 0, 1, 2);
    build_exp(r, 0, 0, 1, 2);
    tests_run++;
    if (!same_q()) begin
      tests_failed++; $display("FAIL slow_stream: got %s want %s", qstr(got_q), qstr(exp_q));
    end
    tests_run++;
    if (!fr_stable_ok) begin
      tests_failed++; $display("FAIL slow_stable: tx_data changed while unaccepted, want stable");
    end
    tests_run++;
    if (!fr_ovr_seen) begin
      tests_failed++; $display("FAIL overrun_pulse: enc_ovr=0 after mid-frame alu_done, want 1");
    end
    tests_run++;
    if (!fr_done_ok || fr_timeout) begin
      tests_failed++; $display("FAIL slow_done: done=%b timeout=%b, want 1/0", fr_done_ok, fr_timeout);
    end
  endtask

  task automatic test_reset_midframe();
    calc_res = 32'h1234_5678; calc_signed = 1'b0; alu_err = 1'b0; alu_done = 1'b1;
    @(negedge clk);
    alu_done = 1'b0; tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++;
    if (uout_valid !== 1'b0 || enc_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_midframe: valid=%b busy=%b, want 0/0", uout_valid, enc_busy);
    end
    tx_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_frame(0, 32'h7, 0, 0, 0, -1);
    exp_q = {8'h37, 8'h0D, 8'h0A};
    tests_run++;
    if (!same_q() || !fr_done_ok) begin
      tests_failed++; $display("FAIL after_reset: got %s want %s", qstr(got_q), qstr(exp_q));
    end
  endtask

  task automatic test_back_to_back();
    run_frame(0, 32'h0000_00AB, 0, 0, 0, -1);
    exp_q = {8'h41, 8'h42, 8'h0D, 8'h0A};
    tests_run++;
    if (!same_q() || !fr_done_ok) begin
      tests_failed++; $display("FAIL b2b_first: got %s want %s", qstr(got_q), qstr(exp_q));
    end
    // Issued in the very cycle enc_done is high
    run_frame(0, 32'hFFFF_FFF1, 1, 0, 0, -1);
    exp_q = {8'h2D, 8'h46, 8'h0D, 8'h0A};
    tests_run++;
    if (!fr_first_ok || !same_q()) begin
      tests_failed++;
      $display("FAIL b2b_second: first=%b got %s want %s", fr_first_ok, qstr(got_q), qstr(exp_q));
    end
  endtask

  task automatic test_random();
    logic [31:0] r;
    bit s, e;
    for (int i = 0; i < 40; i++) begin
      r = $urandom >> $urandom_range(0, 31);
      if (i % 5 == 0) r = $urandom;
      s = 1'($urandom);
      e = ($urandom_range(0, 7) == 0);
      run_frame(0, r, s, e, 2, -1);
      build_exp(r, s, e, 1, 2);
      tests_run++;
      if (!same_q() || !fr_stable_ok || !fr_done_ok || fr_done_early || fr_timeout) begin
        tests_failed++;
        $display("FAIL random_%0d: res=%08h s=%b e=%b got %s want %s", i, r, s, e,
                 qstr(got_q), qstr(exp_q));
      end
    end
  endtask

  initial begin
    rst = 1'b1; alu_done = 1'b0; alu_done2 = 1'b0; alu_err = 1'b0;
    calc_signed = 1'b0; calc_res = '0; tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_hex_unsigned();
    test_signed();
    test_zero();
    test_nolz_random();
    test_error();
    test_slow_ready_overrun();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
